// File: rtl/uart_rx_data_sampler.sv
// uart_rx_data_sampler: UART receiver oversampling front end.
// Counts oversampling edges and bit periods while enabled. Takes three mid-bit
// samples at H-1, H and H+1 (H = P/2) and registers their majority vote with a
// one-cycle valid strobe.
// Optional feature macro: UART_RX_SAMPLER_GLITCH_FLAG_EN. When it is defined,
// glitch_flag reports that the three samples of the last bit disagreed.
// Otherwise glitch_flag is tied to 0.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  glitch_flag
);

  logic                  en_q;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] p_new, p_eff, half;
  logic                  frame_start;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  sampled_q, sampled_d;
  logic                  valid_q, valid_d;
  logic                  majority;

  // Decode the requested ratio. Anything other than 8/16/32 falls back to 8.
  always_comb begin
    p_new = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16)) p_new = PRESCALE_W'(16);
    if (Prescale == PRESCALE_W'(32)) p_new = PRESCALE_W'(32);
  end

  // On the first enabled cycle the freshly decoded ratio drives the
  // comparisons directly. From then on the latched copy is used.
  always_comb begin
    frame_start = enable && !en_q;
    p_eff       = frame_start ? p_new : p_q;
    half        = p_eff >> 1;
    p_d         = frame_start ? p_new : p_q;
  end

  // Edge and bit counters. The bit counter saturates instead of wrapping.
  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (enable) begin
      if (edge_q == p_eff - PRESCALE_W'(1)) begin
        edge_d = '0;
        bit_d  = (bit_q == '1) ? bit_q : bit_q + BIT_CNT_W'(1);
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
        bit_d  = bit_q;
      end
    end
  end

  // Mid-bit sample capture and majority vote. Dropping enable discards any
  // partial samples of the current bit.
  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    valid_d   = 1'b0;
    majority  = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    sampled_d = sampled_q;
    if (!enable) begin
      s0_d = 1'b0;
      s1_d = 1'b0;
    end else begin
      if (edge_q == half - PRESCALE_W'(1)) s0_d = RX_IN;
      if (edge_q == half)                  s1_d = RX_IN;
      if (edge_q == half + PRESCALE_W'(1)) begin
        valid_d   = 1'b1;
        sampled_d = majority;
      end
    end
  end

  // Sampler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      p_q       <= PRESCALE_W'(8);
      edge_q    <= '0;
      bit_q     <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      sampled_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      en_q      <= enable;
      p_q       <= p_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      sampled_q <= sampled_d;
      valid_q   <= valid_d;
    end
  end

`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
  logic glitch_q, glitch_d;

  // The flag is set on a valid cycle whose samples disagree, cleared on a
  // unanimous one, and cleared while the sampler is disabled.
  always_comb begin
    glitch_d = glitch_q;
    if (!enable) begin
      glitch_d = 1'b0;
    end else if (edge_q == half + PRESCALE_W'(1)) begin
      glitch_d = !((s0_q == s1_q) && (s1_q == RX_IN));
    end
  end

  // Glitch flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_q <= 1'b0;
    else     glitch_q <= glitch_d;
  end

  assign glitch_flag = glitch_q;
`else
  assign glitch_flag = 1'b0;
`endif

  assign sampled_bit  = sampled_q;
  assign sample_valid = valid_q;
  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Bench for uart_rx_data_sampler. A frame-position model predicts the outputs:
// for cycle k of a frame, edge = k mod P and bit = min(k div P, 15).
// The valid pulse falls at edge H+2 and votes over the RX values recorded at
// H-1, H and H+1 of that bit.
module tb_uart_rx_data_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       sampled_bit;
  logic       sample_valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       glitch_flag;

  uart_rx_data_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .RX_IN(RX_IN), .Prescale(Prescale),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .glitch_flag(glitch_flag)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic rx [0:1023];
  logic obs_q [$];
  int   exp_edge, exp_bit;
  logic exp_valid, exp_sampled = 1'b0, exp_glitch = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int legal_p(input int pres);
    return (pres == 8 || pres == 16 || pres == 32) ? pres : 8;
  endfunction

  function automatic logic want_glitch();
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
    return exp_glitch;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the expected outputs for cycle k of a frame with ratio p.
  task automatic model_at(input int k, input int p);
    int   bb;
    int   h;
    logic a, b, c;
    h         = p / 2;
    bb        = k / p;
    exp_edge  = k % p;
    exp_bit   = (bb > 15) ? 15 : bb;
    exp_valid = (exp_edge == h + 2);
    if (exp_valid) begin
      a           = rx[bb * p + h - 1];
      b           = rx[bb * p + h];
      c           = rx[bb * p + h + 1];
      exp_sampled = (a & b) | (a & c) | (b & c);
      exp_glitch  = !(a == b && b == c);
    end
  endtask

  // Holds enable high for ncyc cycles and drives RX from rx[]. Prescale
  // switches to pres_new from cycle chg_at onward. The outputs are compared
  // each cycle, and once more at cycle ncyc (enable still high).
  task automatic frame_cycles(input int pres, input int ncyc, input int chg_at, input int pres_new);
    int p;
    p = legal_p(pres);
    obs_q.delete();
    for (int k = 0; k <= ncyc; k++) begin
      model_at(k, p);
      checks += 5;
      if (edge_cnt !== 6'(exp_edge)) begin
        failures++; $display("FAIL edge_cnt k=%0d got=%0d exp=%0d", k, edge_cnt, exp_edge);
      end
      if (bit_cnt !== 4'(exp_bit)) begin
        failures++; $display("FAIL bit_cnt k=%0d got=%0d exp=%0d", k, bit_cnt, exp_bit);
      end
      if (sample_valid !== exp_valid) begin
        failures++; $display("FAIL sample_valid k=%0d got=%b exp=%b", k, sample_valid, exp_valid);
      end
      if (sampled_bit !== exp_sampled) begin
        failures++; $display("FAIL sampled_bit k=%0d got=%b exp=%b", k, sampled_bit, exp_sampled);
      end
      if (glitch_flag !== want_glitch()) begin
        failures++; $display("FAIL glitch_flag k=%0d got=%b exp=%b", k, glitch_flag, want_glitch());
      end
      if (sample_valid === 1'b1) obs_q.push_back(sampled_bit);
      if (k < ncyc) begin
        enable   = 1'b1;
        Prescale = (k >= chg_at) ? 6'(pres_new) : 6'(pres);
        RX_IN    = rx[k];
        tick();
      end
    end
  endtask

  // Drops enable for one cycle and checks that the counters and strobe clear.
  // sampled_bit must hold its value.
  task automatic drop_enable(input string tag);
    enable = 1'b0;
    RX_IN  = 1'($urandom);
    tick();
    exp_glitch = 1'b0;
    checks += 5;
    if (edge_cnt !== 6'd0) begin
      failures++; $display("FAIL %s drop edge_cnt got=%0d exp=0", tag, edge_cnt);
    end
    if (bit_cnt !== 4'd0) begin
      failures++; $display("FAIL %s drop bit_cnt got=%0d exp=0", tag, bit_cnt);
    end
    if (sample_valid !== 1'b0) begin
      failures++; $display("FAIL %s drop sample_valid got=%b exp=0", tag, sample_valid);
    end
    if (sampled_bit !== exp_sampled) begin
      failures++; $display("FAIL %s drop sampled_bit got=%b exp=%b", tag, sampled_bit, exp_sampled);
    end
    if (glitch_flag !== 1'b0) begin
      failures++; $display("FAIL %s drop glitch_flag got=%b exp=0", tag, glitch_flag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({sampled_bit, sample_valid, edge_cnt, bit_cnt, glitch_flag} !== 13'd0) begin
      failures++;
      $display("FAIL reset outputs got=%b/%b/%0d/%0d/%b exp=all zero",
               sampled_bit, sample_valid, edge_cnt, bit_cnt, glitch_flag);
    end
  endtask

  task automatic test_p8_frame();
    logic [9:0] frame;
    frame = 10'b1110011010; // bit 0 is the LSB: 0,1,0,1,1,0,0,1,1,1
    for (int k = 0; k < 81; k++) rx[k] = frame[(k / 8) % 10];
    frame_cycles(8, 80, 9999, 8);
    checks++;
    if (obs_q.size() != 10) begin
      failures++; $display("FAIL p8 valid count got=%0d exp=10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_q[i] !== frame[i]) begin
          failures++; $display("FAIL p8 bit%0d got=%b exp=%b", i, obs_q[i], frame[i]);
        end
      end
    end
    drop_enable("p8");
  endtask

  task automatic test_glitch_p16();
    for (int k = 0; k < 32; k++) rx[k] = 1'b1;
    rx[8] = 1'b0;
    frame_cycles(16, 16, 9999, 16);
    checks += 2;
    if (sampled_bit !== 1'b1) begin
      failures++; $display("FAIL glitch16 sampled_bit got=%b exp=1", sampled_bit);
    end
`ifdef UART_RX_SAMPLER_GLITCH_FLAG_EN
    if (glitch_flag !== 1'b1) begin
      failures++; $display("FAIL glitch16 glitch_flag got=%b exp=1", glitch_flag);
    end
`else
    if (glitch_flag !== 1'b0) begin
      failures++; $display("FAIL glitch16 glitch_flag got=%b exp=0", glitch_flag);
    end
`endif
    drop_enable("glitch16");
  endtask

  task automatic test_prescale_change();
    for (int k = 0; k < 80; k++) rx[k] = (k < 32) ? 1'b0 : 1'b1;
    frame_cycles(32, 64, 5, 8);
    drop_enable("pchg");
  endtask

  task automatic test_illegal_prescale();
    for (int k = 0; k < 40; k++) rx[k] = 1'($urandom);
    frame_cycles(12, 24, 9999, 12);
    drop_enable("p12");
  endtask

  task automatic test_abort();
    logic held;
    for (int k = 0; k < 20; k++) rx[k] = ~exp_sampled;
    held = exp_sampled;
    frame_cycles(16, 4, 9999, 16);
    drop_enable("abort");
    checks++;
    if (sampled_bit !== held) begin
      failures++; $display("FAIL abort sampled_bit got=%b exp=%b", sampled_bit, held);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 100; k++) rx[k] = 1'($urandom);
    frame_cycles(16, 9, 9999, 16);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sampled_bit, sample_valid, edge_cnt, bit_cnt, glitch_flag} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid outputs got=%b/%b/%0d/%0d/%b exp=all zero",
               sampled_bit, sample_valid, edge_cnt, bit_cnt, glitch_flag);
    end
    #1 rst = 1'b0;
    exp_sampled = 1'b0;
    exp_glitch  = 1'b0;
    frame_cycles(32, 40, 9999, 32);
    drop_enable("reset_mid");
  endtask

  task automatic test_random();
    int pres, p, nbits, ncyc;
    logic v;
    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(0, 4))
        0: pres = 8;
        1: pres = 16;
        2: pres = 32;
        default: pres = $urandom_range(0, 63);
      endcase
      p     = legal_p(pres);
      nbits = (f == 0) ? 18 : $urandom_range(1, 6);
      if (f == 0) pres = 8;
      if (f == 0) p = 8;
      ncyc  = nbits * p + $urandom_range(0, p - 1);
      if (ncyc > 1000) ncyc = 1000;
      for (int k = 0; k <= ncyc; k++) begin
        if (k % p == 0) v = 1'($urandom);
        rx[k] = ($urandom_range(0, 7) == 0) ? ~v : v;
      end
      frame_cycles(pres, ncyc, $urandom_range(0, ncyc), $urandom_range(0, 63));
      drop_enable("random");
    end
  endtask

  initial begin
    test_reset();
    test_p8_frame();
    test_glitch_p16();
    test_prescale_change();
    test_illegal_prescale();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
